// File: rtl/rv_io_switch_pkg.sv
// Shared types and helpers for the multi-CPU IO switch: FSM state encoding,
// device-index split point and the one-hot / round-robin helper functions.
package rv_io_switch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_DATA  = 2'd2,
      ST_LOCAL = 2'd3
   } io_state_t;

   localparam int IO_DEV_SHIFT = 12;
   localparam int IO_MAX_PORTS = 32;

   function automatic logic [IO_MAX_PORTS-1:0] onehot(input int idx);
      return IO_MAX_PORTS'(1) << idx;
   endfunction

   // Search starts one past the last winner so every requester is served in turn.
   function automatic int rr_pick(input logic [IO_MAX_PORTS-1:0] req,
                                  input int last, input int n);
      int  pick;
      int  c;
      bit  found;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= n; k++) begin
         c = (last + k) % n;
         if (!found && (((req >> c) & IO_MAX_PORTS'(1)) != '0)) begin
            pick  = c;
            found = 1'b1;
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rv_io_rr_arb.sv
// Combinational round-robin arbiter: picks one requester starting after the
// supplied last-winner pointer; grants only while enabled.
module rv_io_rr_arb
   import rv_io_switch_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   input  logic          en,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic [IO_MAX_PORTS-1:0] req_w;
   int                      pick;

   always_comb begin
      req_w = IO_MAX_PORTS'(req);
      pick  = rr_pick(req_w, int'(last), N);
      valid = en && (|req);
      idx   = IW'(pick);
      grant = valid ? N'(onehot(pick)) : '0;
   end

endmodule

// File: rtl/rv_io_switch.sv
// Multi-CPU IO request switch: round-robin CPU arbitration, one outstanding
// device transaction at a time, local zero response for unmapped addresses.
module rv_io_switch
   import rv_io_switch_pkg::*;
#(
   parameter int NCPU = 2,
   parameter int NDEV = 4,
   parameter int RV   = 64,
   parameter int AW   = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NCPU-1:0]         cpu_addr_req,
   output logic [NCPU-1:0]         cpu_addr_ack,
   input  logic [NCPU*AW-1:0]      cpu_addr,
   input  logic [NCPU-1:0]         cpu_read,
   output logic [NCPU-1:0]         cpu_data_req,
   input  logic [NCPU-1:0]         cpu_data_ack,
   output logic [RV-1:0]           cpu_rdata,
   output logic                    addr_req,
   input  logic [NDEV-1:0]         addr_ack,
   output logic [NDEV-1:0]         sel,
   output logic [IO_DEV_SHIFT-1:0] addr,
   output logic                    read,
   input  logic [NDEV-1:0]         data_req,
   output logic [NDEV-1:0]         data_ack,
   input  logic [NDEV*RV-1:0]      rdata,
   output io_state_t               dbg_state
);

   localparam int CW = (NCPU > 1) ? $clog2(NCPU) : 1;
   localparam int DW = (NDEV > 1) ? $clog2(NDEV) : 1;
   localparam int XW = AW - IO_DEV_SHIFT;

   io_state_t               state_q, state_d;
   logic [CW-1:0]           last_q, g_q;
   logic [DW-1:0]           dev_q;
   logic [IO_DEV_SHIFT-1:0] off_q;
   logic                    read_q;

   logic [NCPU-1:0]         grant;
   logic [CW-1:0]           g_idx;
   logic                    g_valid;
   logic                    arb_en;
   logic [AW-1:0]           sel_addr;
   logic [XW-1:0]           dev_full;
   logic                    mapped;

   // Gating with reset_n keeps the combinational ack at zero while reset is held.
   assign arb_en   = (state_q == ST_IDLE) && reset_n;
   assign sel_addr = cpu_addr[int'(g_idx)*AW +: AW];
   assign dev_full = sel_addr[AW-1:IO_DEV_SHIFT];
   assign mapped   = int'(dev_full) < NDEV;
   assign dbg_state = state_q;

   rv_io_rr_arb #(.N(NCPU), .IW(CW)) u_arb (
      .req   (cpu_addr_req),
      .last  (last_q),
      .en    (arb_en),
      .grant (grant),
      .idx   (g_idx),
      .valid (g_valid)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         last_q  <= CW'(NCPU-1);
         g_q     <= '0;
         dev_q   <= '0;
         off_q   <= '0;
         read_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (g_valid) begin
            last_q <= g_idx;
            g_q    <= g_idx;
            dev_q  <= dev_full[DW-1:0];
            off_q  <= sel_addr[IO_DEV_SHIFT-1:0];
            read_q <= cpu_read[g_idx];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      cpu_addr_ack = grant;
      cpu_data_req = '0;
      cpu_rdata    = '0;
      addr_req     = 1'b0;
      sel          = '0;
      addr         = '0;
      read         = 1'b0;
      data_ack     = '0;
      case (state_q)
         ST_IDLE: begin
            if (g_valid) state_d = mapped ? ST_ADDR : ST_LOCAL;
         end
         ST_ADDR: begin
            addr_req = 1'b1;
            sel      = NDEV'(onehot(int'(dev_q)));
            addr     = off_q;
            read     = read_q;
            if (addr_ack[dev_q]) state_d = read_q ? ST_DATA : ST_IDLE;
         end
         ST_DATA: begin
            // Straight pass-through; late data_req outside this state never reaches a CPU.
            cpu_data_req[g_q] = data_req[dev_q];
            cpu_rdata         = rdata[int'(dev_q)*RV +: RV];
            data_ack[dev_q]   = cpu_data_ack[g_q];
            if (data_req[dev_q] && cpu_data_ack[g_q]) state_d = ST_IDLE;
         end
         ST_LOCAL: begin
            if (read_q) begin
               cpu_data_req[g_q] = 1'b1;
               if (cpu_data_ack[g_q]) state_d = ST_IDLE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   a_ack_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(cpu_addr_ack));
   a_sel_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(sel));

endmodule

// File: tb/tb_rv_io_switch.sv
// Scoreboard bench for rv_io_switch: directed CPU requests, a behavioural device
// model, and a monitor that pops expected acks, device requests and read data.
module tb_rv_io_switch;
   import rv_io_switch_pkg::*;

   localparam int NCPU = 2;
   localparam int NDEV = 4;
   localparam int RV   = 64;
   localparam int AW   = 16;
   localparam logic [RV-1:0] D0 = 64'h0000_0000_DEAD_BEEF;
   localparam logic [RV-1:0] D1 = 64'h0123_4567_89AB_CDEF;
   localparam logic [RV-1:0] D2 = 64'h2222_3333_4444_5555;
   localparam logic [RV-1:0] D3 = 64'hCAFE_F00D_1234_5678;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic [NCPU-1:0]     cpu_addr_req, cpu_addr_ack, cpu_read, cpu_data_req, cpu_data_ack;
   logic [NCPU*AW-1:0]  cpu_addr;
   logic [RV-1:0]       cpu_rdata;
   logic                addr_req, read;
   logic [NDEV-1:0]     addr_ack, sel, data_req, data_ack;
   logic [11:0]         addr;
   logic [NDEV*RV-1:0]  rdata;
   io_state_t           dbg_state;

   always #5 clk = ~clk;

   rv_io_switch #(.NCPU(NCPU), .NDEV(NDEV), .RV(RV), .AW(AW)) dut (
      .clk(clk), .reset_n(reset_n),
      .cpu_addr_req(cpu_addr_req), .cpu_addr_ack(cpu_addr_ack), .cpu_addr(cpu_addr),
      .cpu_read(cpu_read), .cpu_data_req(cpu_data_req), .cpu_data_ack(cpu_data_ack),
      .cpu_rdata(cpu_rdata), .addr_req(addr_req), .addr_ack(addr_ack), .sel(sel),
      .addr(addr), .read(read), .data_req(data_req), .data_ack(data_ack),
      .rdata(rdata), .dbg_state(dbg_state)
   );

   // Devices accept an address in the same cycle it is presented.
   assign addr_ack = addr_req ? sel : '0;

   int checks = 0;
   int passes = 0;

   logic [NCPU-1:0]        exp_ack_q[$];
   logic [NDEV+12:0]       exp_dev_q[$];
   logic [NCPU+RV-1:0]     exp_rd_q[$];
   logic [AW:0]            pend0[$];
   logic [AW:0]            pend1[$];

   int stall = 0;
   logic [NCPU-1:0] ack_seen = '0, dhs_seen = '0;
   logic [NDEV-1:0] addr_rd_seen = '0, dev_hs_seen = '0;
   int cyc = 0, ack_cyc = 0, addr_cyc = 0, rd_cyc = 0, n_rd = 0, stall_cycles = 0;
   bit prev_rd = 0, prev_addr = 0;
   io_state_t state_after_rd = ST_LOCAL, state_after_addr = ST_LOCAL;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic unexpected(input string name);
      checks++;
      $display("FAIL %s: output seen with no expected entry", name);
   endtask

   // Driver: owns every DUT input; changes them only on the falling edge.
   initial begin : driver
      logic [AW:0] item;
      bit          have;
      int          dcnt [NCPU];
      cpu_addr_req = '0; cpu_addr = '0; cpu_read = '0; cpu_data_ack = '0;
      data_req = '0; rdata = {D3, D2, D1, D0};
      for (int i = 0; i < NCPU; i++) dcnt[i] = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            cpu_addr_req = '0; cpu_data_ack = '0; data_req = '0;
            for (int i = 0; i < NCPU; i++) dcnt[i] = 0;
         end else begin
            for (int d = 0; d < NDEV; d++) begin
               if (data_req[d] && dev_hs_seen[d]) data_req[d] = 1'b0;
               if (addr_rd_seen[d]) data_req[d] = 1'b1;
            end
            for (int i = 0; i < NCPU; i++) begin
               if (cpu_addr_req[i] && ack_seen[i]) cpu_addr_req[i] = 1'b0;
               if (!cpu_addr_req[i]) begin
                  have = 0;
                  if (i == 0 && pend0.size() > 0) begin item = pend0.pop_front(); have = 1; end
                  if (i == 1 && pend1.size() > 0) begin item = pend1.pop_front(); have = 1; end
                  if (have) begin
                     cpu_addr[i*AW +: AW] = item[AW-1:0];
                     cpu_read[i]          = item[AW];
                     cpu_addr_req[i]      = 1'b1;
                  end
               end
               if (stall == 0) begin
                  cpu_data_ack[i] = 1'b1;
               end else if (cpu_data_ack[i]) begin
                  if (dhs_seen[i] || !cpu_data_req[i]) begin
                     cpu_data_ack[i] = 1'b0;
                     dcnt[i] = 0;
                  end
               end else if (cpu_data_req[i]) begin
                  if (dcnt[i] >= stall) cpu_data_ack[i] = 1'b1;
                  else dcnt[i]++;
               end
            end
         end
      end
   end

   // Monitor: samples mid-cycle, after the driver has settled the inputs.
   initial begin : monitor
      logic [NCPU+RV-1:0] head;
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         ack_seen     = cpu_addr_ack;
         dhs_seen     = cpu_data_req & cpu_data_ack;
         addr_rd_seen = (addr_req && read) ? (sel & addr_ack) : '0;
         dev_hs_seen  = data_req & data_ack;
         if (reset_n) begin
            if (prev_rd) begin state_after_rd = dbg_state; prev_rd = 0; end
            if (prev_addr) begin state_after_addr = dbg_state; prev_addr = 0; end
            if (|cpu_addr_ack) begin
               check("ack_onehot", 128'($onehot(cpu_addr_ack)), 128'(1));
               if (exp_ack_q.size() == 0) unexpected("cpu_addr_ack");
               else check("ack_grant", 128'(cpu_addr_ack), 128'(exp_ack_q.pop_front()));
               ack_cyc = cyc;
            end
            if (addr_req) begin
               if (exp_dev_q.size() == 0) unexpected("addr_req");
               else check("dev_req", 128'({sel, addr, read}), 128'(exp_dev_q.pop_front()));
               addr_cyc = cyc;
               prev_addr = 1;
            end
            if (|cpu_data_req) begin
               if (exp_rd_q.size() == 0) begin
                  unexpected("cpu_data_req");
               end else if (|(cpu_data_req & cpu_data_ack)) begin
                  check("rdata", 128'({cpu_data_req, cpu_rdata}), 128'(exp_rd_q.pop_front()));
                  rd_cyc = cyc; prev_rd = 1; n_rd++;
               end else begin
                  head = exp_rd_q[0];
                  check("stall_rdata", 128'({cpu_data_req, cpu_rdata}), 128'(head));
                  check("stall_data_ack", 128'(data_ack), 128'(0));
                  stall_cycles++;
               end
            end
         end
      end
   end

   task automatic wait_drain(input string name, input int budget);
      int n = 0;
      while ((pend0.size() + pend1.size() + exp_ack_q.size() + exp_dev_q.size()
              + exp_rd_q.size() != 0 || cpu_addr_req != '0 || dbg_state != ST_IDLE)
             && n < budget) begin
         @(negedge clk); #3; n++;
      end
      checks++;
      if (n >= budget) $display("FAIL %s: timeout after %0d cycles, required drain", name, n);
      else passes++;
      repeat (3) @(negedge clk);
   endtask

   task automatic sync_push;
      @(posedge clk); #1;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ack"},   128'(cpu_addr_ack), 128'(0));
      check({name, "_dreq"},  128'(cpu_data_req), 128'(0));
      check({name, "_rdata"}, 128'(cpu_rdata), 128'(0));
      check({name, "_areq"},  128'({addr_req, sel, addr, read}), 128'(0));
      check({name, "_dack"},  128'(data_ack), 128'(0));
      check({name, "_state"}, 128'(dbg_state), 128'(ST_IDLE));
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", passes, checks + 1);
      $fatal(1);
   end

   initial begin : main
      int s0;
      int loops;
      repeat (3) @(negedge clk);
      #1 reset_n = 1'b1;
      @(negedge clk); #3;
      check_all_zero("reset");

      // Simultaneous reads from both CPUs straight out of reset: grants 0, 1, 0.
      sync_push();
      pend0.push_back({1'b1, 16'h0010});
      pend0.push_back({1'b1, 16'h1008});
      pend1.push_back({1'b1, 16'h3FF8});
      exp_ack_q.push_back(2'b01); exp_ack_q.push_back(2'b10); exp_ack_q.push_back(2'b01);
      exp_dev_q.push_back({4'b0001, 12'h010, 1'b1});
      exp_dev_q.push_back({4'b1000, 12'hFF8, 1'b1});
      exp_dev_q.push_back({4'b0010, 12'h008, 1'b1});
      exp_rd_q.push_back({2'b01, D0}); exp_rd_q.push_back({2'b10, D3});
      exp_rd_q.push_back({2'b01, D1});
      wait_drain("simul", 200);
      check("simul_count", 128'(n_rd), 128'(3));

      // Single minimum-latency read from CPU0 to dev0.
      state_after_rd = ST_LOCAL;
      sync_push();
      pend0.push_back({1'b1, 16'h0018});
      exp_ack_q.push_back(2'b01);
      exp_dev_q.push_back({4'b0001, 12'h018, 1'b1});
      exp_rd_q.push_back({2'b01, D0});
      wait_drain("single", 100);
      check("single_addr_lat", 128'(addr_cyc - ack_cyc), 128'(1));
      check("single_data_lat", 128'(rd_cyc - ack_cyc), 128'(2));
      check("single_idle", 128'(state_after_rd), 128'(ST_IDLE));

      // Write to dev2: address only, no read data returned.
      state_after_addr = ST_LOCAL;
      s0 = n_rd;
      sync_push();
      pend1.push_back({1'b0, 16'h2040});
      exp_ack_q.push_back(2'b10);
      exp_dev_q.push_back({4'b0100, 12'h040, 1'b0});
      wait_drain("write", 100);
      check("write_idle", 128'(state_after_addr), 128'(ST_IDLE));
      check("write_no_data", 128'(n_rd - s0), 128'(0));

      // Unmapped read answered locally with zero, CPU delays its accept.
      stall = 2;
      s0 = stall_cycles;
      sync_push();
      pend0.push_back({1'b1, 16'h7000});
      exp_ack_q.push_back(2'b01);
      exp_rd_q.push_back({2'b01, 64'h0});
      wait_drain("unmapped_rd", 100);
      check("unmapped_held", 128'((stall_cycles - s0) >= 2), 128'(1));

      // Unmapped write completes with no visible traffic.
      sync_push();
      pend1.push_back({1'b0, 16'h5000});
      exp_ack_q.push_back(2'b10);
      wait_drain("unmapped_wr", 100);

      // CPU1 stalls its data accept: pass-through must stay stable.
      stall = 5;
      s0 = stall_cycles;
      sync_push();
      pend1.push_back({1'b1, 16'h1100});
      exp_ack_q.push_back(2'b10);
      exp_dev_q.push_back({4'b0010, 12'h100, 1'b1});
      exp_rd_q.push_back({2'b10, D1});
      wait_drain("stall", 150);
      check("stall_len", 128'((stall_cycles - s0) >= 5), 128'(1));

      // Reset while in DATA with read data pending.
      sync_push();
      pend0.push_back({1'b1, 16'h3010});
      exp_ack_q.push_back(2'b01);
      exp_dev_q.push_back({4'b1000, 12'h010, 1'b1});
      exp_rd_q.push_back({2'b01, D3});
      loops = 0;
      do begin
         @(negedge clk); #3; loops++;
      end while (!(dbg_state == ST_DATA && cpu_data_req != '0) && loops < 50);
      check("pre_reset_dreq", 128'(cpu_data_req), 128'(2'b01));
      #1 reset_n = 1'b0;
      #1 check_all_zero("async_reset");
      exp_rd_q.delete();
      exp_ack_q.delete();
      exp_dev_q.delete();
      stall = 0;
      repeat (2) @(negedge clk);
      #1 reset_n = 1'b1;
      sync_push();
      pend0.push_back({1'b1, 16'h0020});
      pend1.push_back({1'b1, 16'h1040});
      exp_ack_q.push_back(2'b01); exp_ack_q.push_back(2'b10);
      exp_dev_q.push_back({4'b0001, 12'h020, 1'b1});
      exp_dev_q.push_back({4'b0010, 12'h040, 1'b1});
      exp_rd_q.push_back({2'b01, D0}); exp_rd_q.push_back({2'b10, D1});
      wait_drain("post_reset", 200);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/rv_io_switch.md
# rv_io_switch

Multi-CPU IO request switch. It sits directly upstream of the IO devices, such as the DTB ROM responder, and arbitrates round-robin among NCPU CPU IO ports. It forwards one transaction at a time to the device selected by address decode, then routes that device's read data back to the requesting CPU. Unmapped addresses are answered locally so that a CPU never hangs.

## Interface
- NCPU, 2: number of CPU request ports (≥2).
- NDEV, 4: number of device ports.
- RV, 64: data width.
- AW, 16: IO address width; device index is addr[AW-1:12], offset is addr[11:0].
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cpu_addr_req  in  NCPU  per-CPU request valid; held until acked.
- cpu_addr_ack  out  NCPU  one-hot request accept.
- cpu_addr  in  NCPU*AW  per-CPU address, CPU i at [i*AW +: AW].
- cpu_read  in  NCPU  1 = read, 0 = write (write data is out of scope; writes are address-only).
- cpu_data_req  out  NCPU  read data valid to CPU.
- cpu_data_ack  in  NCPU  CPU accepts read data.
- cpu_rdata  out  RV  read data, shared bus, valid where cpu_data_req is set.
- addr_req  out  1  device request valid.
- addr_ack  in  NDEV  per-device accept.
- sel  out  NDEV  one-hot device select.
- addr  out  12  device offset.
- read  out  1  device read strobe.
- data_req  in  NDEV  per-device read data valid.
- data_ack  out  NDEV  per-device data accept.
- rdata  in  NDEV*RV  per-device read data.

## Operation
- State machine has four states: IDLE, ADDR, DATA, LOCAL.
- IDLE:
  - If any cpu_addr_req is set, pick grant g round-robin, searching from last_grant+1 modulo NCPU.
  - Register g, the address and the read bit.
  - Assert cpu_addr_ack[g] in this cycle, combinationally from the request vector.
  - Decode the device index. If index < NDEV, go to ADDR; otherwise go to LOCAL.
- ADDR:
  - Drive addr_req=1, sel=onehot(dev), addr and read from the registers.
  - When addr_ack[dev] is set: a write goes to IDLE; a read goes to DATA.
- DATA:
  - Pass through combinationally: cpu_data_req[g]=data_req[dev], cpu_rdata=rdata[dev], data_ack[dev]=cpu_data_ack[g].
  - When data_req[dev] and cpu_data_ack[g] are both set, go to IDLE.
- LOCAL:
  - A read drives cpu_data_req[g]=1 with cpu_rdata=0 until cpu_data_ack[g] is set, then goes to IDLE.
  - A write goes to IDLE immediately.
- last_grant updates only when a request is accepted in IDLE.
- Outputs are zero for all ports and devices other than g and dev.
- data_req from a device that is not in DATA is ignored. This covers a device dropping r_req one cycle late.

## Timing
- Reset values: state IDLE, last_grant NCPU-1 (so CPU 0 wins first), all outputs 0.
- CPU accept takes 0 cycles: cpu_addr_ack is asserted in the IDLE cycle.
- The device addr_req appears the next cycle.
- Devices assert data_req at least 1 cycle after their addr handshake and hold it until data_ack.
- Minimum read, against a device that answers 1 cycle after its addr handshake: CPU ack at T, addr_req at T+1, data_req at T+2, back in IDLE at T+3.
- Back-to-back: IDLE accepts the next request in the cycle after completion.
- Only one transaction is outstanding at a time; no pipelining.
- Simultaneous requests: exactly one ack is asserted; the others stay pending.
- Reset asserted mid-transaction: immediate return to IDLE with outputs 0. Any in-flight device response is dropped.
- cpu_addr_req falling after ack has no effect.

## Structure
- The shared package holds:
  - state enum;
  - IO_DEV_SHIFT=12;
  - the onehot/round-robin function.
- Sub-module rv_io_rr_arb: NCPU-wide round-robin arbiter with req, last pointer and update enable in, one-hot grant and index out.

## Test plan
- Single read, CPU0, addr 0x0018 to dev0 with rdata 0xDEAD_BEEF, device answering 1 cycle after its addr handshake:
  - cpu_addr_ack[0] at T, addr_req/sel=0001/addr=0x018 at T+1;
  - cpu_data_req[0] with 0xDEAD_BEEF at T+2, IDLE at T+3.
- Simultaneous reads from CPU0 and CPU1 held for 3 transactions: grants in order 0, 1, 0; never two acks in one cycle.
- Write to dev2 addr 0x2040 with read=0: addr_req and sel=0100; no cpu_data_req; IDLE after addr_ack[2].
- Unmapped read at addr 0x7000 with NDEV=4: no addr_req; cpu_data_req=1 with rdata 0 until ack.
- CPU stalls cpu_data_ack for 5 cycles: data_ack[dev] stays 0 and data passes through stable.
- reset_n dropped in DATA: all outputs 0 asynchronously; after release the next request is served by CPU0.
